vga_pattern_gen: RTL and testbench

Pixel-source stage for the 640x480 VGA path. Consumes the position/blanking outputs of `vga_hvsync_gen` and produces one of four selectable test patterns as 4-bit RGB. The sync and display-enable signals are delayed so they stay aligned with the colour pipeline. Output feeds the colour output register stage `d_ff_all_colors` and the VGA pins. Pattern mode changes are handshaked and take effect only at a frame boundary, so no frame is torn.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_sync_delay.sv | 31 +++
 rtl/vga_pattern_gen.sv | 211 +++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the 640x480 VGA pixel path.
package vga_pkg;

    // 640x480 @ 60 Hz timing
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_TOTAL  = 525;

    localparam int POS_W   = 10;
    localparam int COLOR_W = 4;
    localparam int FRAME_W = 8;

    // Selectable test patterns
    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // Mode-request handshake: IDLE accepts a request, PENDING waits for the
    // next frame boundary to apply it.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } mode_state_e;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage delay line used to keep sync/enable aligned with the colour pipeline.
module vga_sync_delay #(
    parameter int            W       = 1,
    parameter int            N       = 2,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] pipe_q [N];

    // Shift register; every stage resets to the idle level of the signal
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                pipe_q[i] <= RST_VAL;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[N-1];

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: two-stage colour pipeline, frame counter and
// frame-synchronous mode switching.
//
// Handshake: a request transfers on any cycle where mode_req_valid and
// mode_req_ready are both high. After a transfer ready stays low until the
// next frame boundary (hpos==0, vpos==V_ACTIVE) applies the latched mode,
// and rises the cycle after that boundary.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE    = VGA_H_ACTIVE,
    parameter int   V_ACTIVE    = VGA_V_ACTIVE,
    parameter int   BAR_W       = 80,
    parameter int   CHECK_SHIFT = 5,
    parameter logic SYNC_IDLE   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [POS_W-1:0]   hpos,
    input  logic [POS_W-1:0]   vpos,
    input  logic               display_on,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [1:0]         mode_req,
    input  logic               mode_req_valid,
    output logic               mode_req_ready,
    output logic [1:0]         mode_cur,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               de_out,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b
);

    localparam int COL_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    // Frame boundary: first cycle of vertical blanking
    logic fb;
    assign fb = (hpos == '0) && (vpos == POS_W'(V_ACTIVE));

    // ---------------------------------------------------------------
    // Frame counter
    // ---------------------------------------------------------------
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = fb ? frame_cnt_q + FRAME_W'(1) : frame_cnt_q;

    // Count frames, wrapping naturally at 2^FRAME_W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end

    // ---------------------------------------------------------------
    // Mode handshake FSM
    // ---------------------------------------------------------------
    mode_state_e state_q;
    mode_e       mode_cur_q;
    mode_e       pend_q;
    logic        ready_q;

    // Latch a request while idle; apply it at the next frame boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            mode_cur_q <= MODE_BARS;
            pend_q     <= MODE_BARS;
            ready_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A request coinciding with a boundary waits for the next one
                    if (mode_req_valid) begin
                        pend_q  <= mode_e'(mode_req);
                        state_q <= ST_PENDING;
                        ready_q <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (fb) begin
                        mode_cur_q <= pend_q;
                        state_q    <= ST_IDLE;
                        ready_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign mode_req_ready = ready_q;
    assign mode_cur       = mode_cur_q;
    assign frame_cnt      = frame_cnt_q;

    // ---------------------------------------------------------------
    // Stage 1: registered position, enable and colour-bar index
    // ---------------------------------------------------------------
    logic [POS_W-1:0] hpos_s1_q, vpos_s1_q;
    logic             de_s1_q;
    logic [COL_W-1:0] col_q, col_d;
    logic [2:0]       bar_q, bar_d;

    // Column counter replaces hpos/BAR_W; saturates at the last bar
    always_comb begin
        col_d = col_q;
        bar_d = bar_q;
        if (hpos == '0) begin
            col_d = '0;
            bar_d = '0;
        end else if (hpos < POS_W'(H_ACTIVE)) begin
            if (col_q == COL_W'(BAR_W - 1)) begin
                col_d = '0;
                if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Stage-1 register bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos_s1_q <= '0;
            vpos_s1_q <= '0;
            de_s1_q   <= 1'b0;
            col_q     <= '0;
            bar_q     <= '0;
        end else begin
            hpos_s1_q <= hpos;
            vpos_s1_q <= vpos;
            de_s1_q   <= display_on;
            col_q     <= col_d;
            bar_q     <= bar_d;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: pattern colour with blanking
    // ---------------------------------------------------------------
    logic [2:0]       bar_idx;
    logic [POS_W-1:0] chk_x;
    rgb_t             pix_d, pix_q;

    assign bar_idx = 3'd7 - bar_q;
    assign chk_x   = hpos_s1_q + POS_W'(frame_cnt_q);

    // Select the pattern colour for the stage-1 pixel, black when blanked
    always_comb begin
        pix_d = '0;
        case (mode_cur_q)
            MODE_BARS: begin
                pix_d.r = {COLOR_W{bar_idx[2]}};
                pix_d.g = {COLOR_W{bar_idx[1]}};
                pix_d.b = {COLOR_W{bar_idx[0]}};
            end
            MODE_CHECK: begin
                if (chk_x[CHECK_SHIFT] ^ vpos_s1_q[CHECK_SHIFT]) pix_d = '1;
            end
            MODE_GRAD: begin
                pix_d.r = hpos_s1_q[9:6];
                pix_d.g = vpos_s1_q[8:5];
                pix_d.b = frame_cnt_q[7:4];
            end
            MODE_SOLID: begin
                pix_d = '1;
            end
            default: pix_d = '0;
        endcase
        if (!de_s1_q) pix_d = '0;
    end

    // Stage-2 colour register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pix_q <= '0;
        else        pix_q <= pix_d;
    end

    assign r = pix_q.r;
    assign g = pix_q.g;
    assign b = pix_q.b;

    // Only some position bits feed the patterns
    logic unused_bits;
    assign unused_bits = ^{chk_x, vpos_s1_q};

    // ---------------------------------------------------------------
    // Sync / enable delay, matched to the two colour stages
    // ---------------------------------------------------------------
    logic [2:0] sync_dly;

    vga_sync_delay #(
        .W       (3),
        .N       (2),
        .RST_VAL ({SYNC_IDLE, SYNC_IDLE, 1'b0})
    ) u_sync_delay (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    ({hsync_in, vsync_in, display_on}),
        .q_o    (sync_dly)
    );

    assign hsync_out = sync_dly[2];
    assign vsync_out = sync_dly[1];
    assign de_out    = sync_dly[0];

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen with a reference model and an
// expected-output queue aligned to the two-cycle pipeline.
module tb_vga_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos, vpos;
    logic       display_on, hsync_in, vsync_in;
    logic [1:0] mode_req;
    logic       mode_req_valid;
    logic       mode_req_ready;
    logic [1:0] mode_cur;
    logic [7:0] frame_cnt;
    logic       hsync_out, vsync_out, de_out;
    logic [3:0] r, g, b;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .clk            (clk),
        .reset          (reset),
        .hpos           (hpos),
        .vpos           (vpos),
        .display_on     (display_on),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .mode_req       (mode_req),
        .mode_req_valid (mode_req_valid),
        .mode_req_ready (mode_req_ready),
        .mode_cur       (mode_cur),
        .frame_cnt      (frame_cnt),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .de_out         (de_out),
        .r              (r),
        .g              (g),
        .b              (b)
    );

    // ---------------- scoreboard state ----------------
    logic [14:0] exp_q[$];   // {de, hsync, vsync, r, g, b}
    int total = 0;
    int bad   = 0;

    // reference model of the mode/frame registers
    int m_mode  = 0;
    int m_pend  = 0;
    int m_frame = 0;
    bit m_idle  = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] model_pix(input int h, input int v, input int mode, input int fc);
        logic [9:0] hv, vv;
        logic [7:0] f8;
        int idx, x, w;
        hv = 10'(h);
        vv = 10'(v);
        f8 = 8'(fc);
        case (mode)
            0: begin
                idx = h / 80;
                if (idx > 7) idx = 7;
                idx = 7 - idx;
                return {((idx & 4) != 0) ? 4'hF : 4'h0,
                        ((idx & 2) != 0) ? 4'hF : 4'h0,
                        ((idx & 1) != 0) ? 4'hF : 4'h0};
            end
            1: begin
                x = (h + fc) % 1024;
                w = ((x >> 5) & 1) ^ ((v >> 5) & 1);
                return (w != 0) ? 12'hFFF : 12'h000;
            end
            2: return {hv[9:6], vv[8:5], f8[7:4]};
            default: return 12'hFFF;
        endcase
    endfunction

    function automatic void model_reset();
        m_mode  = 0;
        m_pend  = 0;
        m_frame = 0;
        m_idle  = 1'b1;
        exp_q.delete();
    endfunction

    // ---------------- driver ----------------
    // Drive one pixel cycle (called at a negedge), advance the model, then
    // check status outputs and the pixel that left the pipeline.
    task automatic px(input int h, input int v, input bit de, input bit valid, input logic [1:0] req);
        bit hs, vs, fb;
        logic [11:0] c;
        logic [14:0] e;
        hs = !(h >= 656 && h < 752);
        vs = !(v >= 490 && v < 492);
        hpos = 10'(h);
        vpos = 10'(v);
        display_on = de;
        hsync_in = hs;
        vsync_in = vs;
        mode_req_valid = valid;
        mode_req = req;

        fb = (h == 0 && v == 480);
        if (m_idle) begin
            if (valid) begin
                m_pend = int'(req);
                m_idle = 1'b0;
            end
        end else if (fb) begin
            m_mode = m_pend;
            m_idle = 1'b1;
        end
        if (fb) m_frame = (m_frame + 1) % 256;
        c = de ? model_pix(h, v, m_mode, m_frame) : 12'h000;
        exp_q.push_back({de, hs, vs, c});

        @(posedge clk);
        @(negedge clk);
        check("mode_cur", mode_cur, m_mode);
        check("frame_cnt", frame_cnt, m_frame);
        check("mode_req_ready", mode_req_ready, m_idle);
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check("de_out", de_out, e[14]);
            check("hsync_out", hsync_out, e[13]);
            check("vsync_out", vsync_out, e[12]);
            check("rgb", {r, g, b}, e[11:0]);
        end
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) px(799, 524, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic vis_line(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) px(h, v, (h < 640), 1'b0, 2'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_r"}, r, 4'h0);
        check({tag, "_g"}, g, 4'h0);
        check({tag, "_b"}, b, 4'h0);
        check({tag, "_de"}, de_out, 1'b0);
        check({tag, "_hs"}, hsync_out, 1'b1);
        check({tag, "_vs"}, vsync_out, 1'b1);
        check({tag, "_mode"}, mode_cur, 2'd0);
        check({tag, "_frame"}, frame_cnt, 8'd0);
        check({tag, "_ready"}, mode_req_ready, 1'b1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b0;
        hpos = '0;
        vpos = '0;
        display_on = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        mode_req = 2'd0;
        mode_req_valid = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        check_reset_vals("reset");
        reset = 1'b1;

        // colour bars on line 0, then horizontal blanking with hsync pulse
        vis_line(0, 0, 799);
        flush(2);

        // mode change requested mid-frame
        for (int h = 0; h <= 20; h++) begin
            px(h, 100, 1'b1, (h == 10), 2'd2);
            if (h == 10) check("ready_fall", mode_req_ready, 1'b0);
        end
        vis_line(100, 21, 639);
        flush(2);
        px(0, 480, 1'b0, 1'b0, 2'd0);
        check("mode_after_fb", mode_cur, 2'd2);
        check("ready_after_fb", mode_req_ready, 1'b1);
        for (int h = 1; h <= 5; h++) px(h, 480, 1'b0, 1'b0, 2'd0);
        for (int h = 0; h <= 5; h++) px(h, 490, 1'b0, 1'b0, 2'd0);
        flush(1);
        // first frame in gradient mode
        vis_line(0, 0, 799);
        vis_line(32, 0, 639);
        flush(2);

        // request exactly on the frame boundary
        px(0, 480, 1'b0, 1'b1, 2'd1);
        check("fb_req_mode_kept", mode_cur, 2'd2);
        check("fb_req_accepted", mode_req_ready, 1'b0);
        for (int h = 1; h <= 3; h++) px(h, 480, 1'b0, 1'b0, 2'd0);
        vis_line(0, 0, 63);
        flush(2);
        px(0, 480, 1'b0, 1'b0, 2'd0);
        check("fb_req_applied", mode_cur, 2'd1);
        flush(2);

        // checker mode across a full frame-counter wrap
        for (int f = 0; f < 260; f++) begin
            vis_line(0, 0, 79);
            if (m_frame == 0 || m_frame == 32) vis_line(40, 0, 127);
            flush(2);
            px(0, 480, 1'b0, 1'b0, 2'd0);
            if (m_frame == 0) check("frame_wrap", frame_cnt, 8'd0);
            flush(2);
        end

        // solid white
        vis_line(0, 0, 10);
        px(11, 0, 1'b1, 1'b1, 2'd3);
        vis_line(0, 12, 99);
        flush(2);
        px(0, 480, 1'b0, 1'b0, 2'd0);
        check("solid_applied", mode_cur, 2'd3);
        flush(2);
        vis_line(0, 0, 99);

        // asynchronous reset while a request is pending, mid-line
        for (int h = 100; h <= 160; h++) px(h, 0, 1'b1, (h == 120), 2'd2);
        check("pending_before_reset", mode_req_ready, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check_reset_vals("async_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("post_reset_mode", mode_cur, 2'd0);
        check("post_reset_ready", mode_req_ready, 1'b1);
        vis_line(0, 0, 199);
        flush(3);
        px(0, 480, 1'b0, 1'b0, 2'd0);
        check("post_reset_no_apply", mode_cur, 2'd0);
        flush(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
